// File: rtl/rs5_mem16_bridge.sv
// Bridges RS5 byte-addressed 32-bit loads/stores onto a 16-bit-word RAM with a
// registered dual-word read port; partial stores become read-modify-write.
module rs5_mem16_bridge #(
    parameter int MEM_WIDTH  = 65536,
    parameter int ADDR_WIDTH = 32,
    localparam int AW        = $clog2(MEM_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_i,
    input  logic [3:0]            we_i,
    input  logic [1:0]            size_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  busy_o,
    output logic                  ram_en_o,
    output logic                  ram_we_o,
    output logic [AW-1:0]         ram_addr_o,
    output logic [31:0]           ram_data_o,
    input  logic [31:0]           ram_data_a_i,
    input  logic [31:0]           ram_data_b_i
);

    typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR_LO, WR_HI, ACK} state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(MEM_WIDTH - 1);

    state_t        state;
    logic [AW-1:0] idx_q;
    logic          odd_q, load_q, merge_q, hi_q, err_q, ack_q;
    logic [1:0]    size_q;
    logic [31:0]   wdata_q, rdata_q;
    logic          ram_en_q, ram_we_q;
    logic [AW-1:0] ram_addr_q;
    logic [15:0]   ram_wd_q;

    logic [AW-1:0] idx;
    logic          odd, is_rd, is_byte, is_half, is_word;
    logic          bad_we, word_acc, needs_hi, req_err;
    logic [31:0]   pair, shifted, rd_val;
    logic [15:0]   merge_lo;

    always_comb begin
        idx      = addr_i[AW:1];
        odd      = addr_i[0];
        is_rd    = (we_i == 4'b0000);
        is_byte  = (we_i == 4'b0001);
        is_half  = (we_i == 4'b0011);
        is_word  = (we_i == 4'b1111);
        bad_we   = !(is_rd || is_byte || is_half || is_word);
        word_acc = (is_rd && size_i[1]) || is_word;
        // Accesses that touch idx+1 must not run off the top of the RAM.
        needs_hi = (is_rd && (size_i[1] || (size_i == 2'd1 && odd)))
                 || is_word || (is_half && odd);
        req_err  = bad_we || (word_acc && odd) || (needs_hi && idx == LAST_IDX);
    end

    always_comb begin
        pair    = {ram_data_b_i[15:0], ram_data_a_i[15:0]};
        shifted = odd_q ? (pair >> 8) : pair;
        case (size_q)
            2'd0:    rd_val = {24'h0, shifted[7:0]};
            2'd1:    rd_val = {16'h0, shifted[15:0]};
            default: rd_val = shifted;
        endcase
        merge_lo = odd_q ? {wdata_q[7:0], ram_data_a_i[7:0]}
                         : {ram_data_a_i[15:8], wdata_q[7:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx_q      <= '0;
            odd_q      <= 1'b0;
            load_q     <= 1'b0;
            merge_q    <= 1'b0;
            hi_q       <= 1'b0;
            err_q      <= 1'b0;
            ack_q      <= 1'b0;
            size_q     <= 2'd0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_wd_q   <= '0;
        end else begin
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
            case (state)
                IDLE: if (req_i) begin
                    idx_q      <= idx;
                    odd_q      <= odd;
                    size_q     <= size_i;
                    wdata_q    <= wdata_i;
                    load_q     <= is_rd;
                    merge_q    <= is_byte || (is_half && odd);
                    hi_q       <= is_word || (is_half && odd);
                    ram_addr_q <= idx;
                    if (req_err) begin
                        state <= ACK;
                        ack_q <= 1'b1;
                        err_q <= 1'b1;
                    end else if (is_rd) begin
                        state    <= RD;
                        ram_en_q <= 1'b1;
                    end else if (is_byte || (is_half && odd)) begin
                        state    <= RMW_RD;
                        ram_en_q <= 1'b1;
                    end else begin
                        state    <= WR_LO;
                        ram_en_q <= 1'b1;
                        ram_we_q <= 1'b1;
                        ram_wd_q <= wdata_i[15:0];
                    end
                end
                RD: begin
                    state <= ACK;
                    ack_q <= 1'b1;
                end
                RMW_RD: begin
                    state    <= WR_LO;
                    ram_en_q <= 1'b1;
                    ram_we_q <= 1'b1;
                end
                WR_LO: if (hi_q) begin
                    // b is still the RMW read result here; latch the merged high word now.
                    state      <= WR_HI;
                    ram_en_q   <= 1'b1;
                    ram_we_q   <= 1'b1;
                    ram_addr_q <= idx_q + AW'(1);
                    ram_wd_q   <= merge_q ? {ram_data_b_i[15:8], wdata_q[15:8]}
                                          : wdata_q[31:16];
                end else begin
                    state <= ACK;
                    ack_q <= 1'b1;
                end
                WR_HI: begin
                    state <= ACK;
                    ack_q <= 1'b1;
                end
                ACK: begin
                    state <= IDLE;
                    if (load_q) rdata_q <= err_q ? 32'h0 : rd_val;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Merged low word and load data come straight off the RAM read port in the
    // cycle it becomes valid; everything else leaves from a register.
    assign ram_data_o = {16'h0, (state == WR_LO && merge_q) ? merge_lo : ram_wd_q};
    assign rdata_o    = (state == ACK && (load_q || err_q)) ? (err_q ? 32'h0 : rd_val)
                                                            : rdata_q;
    assign ack_o      = ack_q;
    assign err_o      = err_q;
    assign busy_o     = (state != IDLE);
    assign ram_en_o   = ram_en_q;
    assign ram_we_o   = ram_we_q;
    assign ram_addr_o = ram_addr_q;

    logic unused_bits;
    assign unused_bits = ^{ram_data_a_i[31:16], ram_data_b_i[31:16],
                           addr_i[ADDR_WIDTH-1:AW+1]};

endmodule

// File: tb/tb_rs5_mem16_bridge.sv
// Directed bench for rs5_mem16_bridge with a behavioural 16-bit dual-read RAM.
module tb_rs5_mem16_bridge;

    localparam int MEM_WIDTH = 65536;
    localparam int AW        = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_i = 1'b0;
    logic [3:0]  we_i = 4'h0;
    logic [1:0]  size_i = 2'd0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic [31:0] rdata_o;
    logic        ack_o, err_o, busy_o, ram_en_o, ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_a = 32'h0;
    logic [31:0] ram_b = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] mem [0:MEM_WIDTH-1];

    always #5 clk = ~clk;

    rs5_mem16_bridge #(.MEM_WIDTH(MEM_WIDTH), .ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i), .size_i(size_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .ack_o(ack_o),
        .err_o(err_o), .busy_o(busy_o), .ram_en_o(ram_en_o), .ram_we_o(ram_we_o),
        .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
        .ram_data_a_i(ram_a), .ram_data_b_i(ram_b)
    );

    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_we_o) mem[ram_addr_o] <= ram_data_o[15:0];
            else begin
                ram_a <= {16'h0, mem[ram_addr_o]};
                ram_b <= {16'h0, mem[ram_addr_o + 16'd1]};
            end
        end
    end

    // Issue one request and wait (bounded) for its ack; lat = ack cycle after acceptance.
    task automatic run_req(input logic [3:0] we, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wd, output int lat, output logic err,
                           output logic [31:0] rd, output int en_cnt, output logic busy_ack);
        lat = -1; err = 1'b0; rd = 32'h0; en_cnt = 0; busy_ack = 1'b0;
        @(negedge clk);
        req_i = 1'b1; we_i = we; size_i = sz; addr_i = addr; wdata_i = wd;
        @(posedge clk);
        #1 req_i = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (ram_en_o) en_cnt++;
            if (ack_o) begin
                lat = c; err = err_o; rd = rdata_o; busy_ack = busy_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lat, en_cnt, bad_cyc;
        logic err, busy_ack;
        logic [31:0] rd;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({ack_o, err_o, busy_o, ram_en_o, ram_we_o} !== 5'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {ack_o, err_o, busy_o, ram_en_o, ram_we_o});
        end
        n_cmp++;
        if ({rdata_o, ram_data_o, ram_addr_o} !== 80'h0) begin
            n_bad++; $display("FAIL reset_data: got %h/%h/%h want 0", rdata_o, ram_data_o, ram_addr_o);
        end
        reset = 1'b0;
        run_req(4'b0011, 2'd0, 32'h22, 32'h0000_1111, lat, err, rd, en_cnt, busy_ack);
        n_cmp++;
        if (lat !== 2) begin n_bad++; $display("FAIL reset_pre_lat: got %0d want 2", lat); end
        // Word store interrupted right after WR_LO is issued.
        @(negedge clk);
        req_i = 1'b1; we_i = 4'b1111; size_i = 2'd0; addr_i = 32'h20; wdata_i = 32'hCAFE_F00D;
        @(posedge clk);
        #1 req_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ram_en_o, ram_we_o, ram_addr_o} !== {2'b11, 16'd16}) begin
            n_bad++; $display("FAIL reset_wrlo: got %b%b@%0d want 11@16", ram_en_o, ram_we_o, ram_addr_o);
        end
        reset = 1'b1;
        bad_cyc = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if ({ack_o, err_o, busy_o, ram_en_o, ram_we_o} !== 5'b0 || rdata_o !== 32'h0
                || ram_data_o !== 32'h0 || ram_addr_o !== 16'h0) bad_cyc++;
        end
        n_cmp++;
        if (bad_cyc !== 0) begin n_bad++; $display("FAIL reset_hold_outputs: got %0d nonzero cycles want 0", bad_cyc); end
        reset = 1'b0;
        bad_cyc = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ack_o || ram_en_o || busy_o) bad_cyc++;
        end
        n_cmp++;
        if (bad_cyc !== 0) begin n_bad++; $display("FAIL reset_no_resume: got %0d active cycles want 0", bad_cyc); end
        n_cmp++;
        if (mem[16] !== 16'hF00D) begin n_bad++; $display("FAIL reset_lo_done: got %h want f00d", mem[16]); end
        n_cmp++;
        if (mem[17] !== 16'h1111) begin n_bad++; $display("FAIL reset_hi_kept: got %h want 1111", mem[17]); end
    endtask

    task automatic test_word();
        int lat, en_cnt;
        logic err, busy_ack;
        logic [31:0] rd;
        run_req(4'b1111, 2'd2, 32'h10, 32'hDEAD_BEEF, lat, err, rd, en_cnt, busy_ack);
        n_cmp++;
        if (lat !== 3 || err !== 1'b0) begin n_bad++; $display("FAIL word_st_ack: got lat %0d err %b want 3/0", lat, err); end
        n_cmp++;
        if (mem[8] !== 16'hBEEF || mem[9] !== 16'hDEAD) begin
            n_bad++; $display("FAIL word_st_ram: got %h %h want beef dead", mem[8], mem[9]);
        end
        run_req(4'b0000, 2'd2, 32'h10, 32'h0, lat, err, rd, en_cnt, busy_ack);
        n_cmp++;
        if (lat !== 2) begin n_bad++; $display("FAIL word_rd_lat: got %0d want 2", lat); end
        n_cmp++;
        if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL word_rd_data: got %h want deadbeef", rd); end
        n_cmp++;
        if (busy_ack !== 1'b1) begin n_bad++; $display("FAIL busy_at_ack: got %b want 1", busy_ack); end
        @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b0 || rdata_o !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL after_ack: got busy %b rdata %h want 0 deadbeef", busy_o, rdata_o);
        end
    endtask

    task automatic test_byte_store();
        int lat, en_cnt;
        logic err, busy_ack;
        logic [31:0] rd;
        run_req(4'b0001, 2'd0, 32'h11, 32'h0000_00A5, lat, err, rd, en_cnt, busy_ack);
        n_cmp++;
        if (lat !== 3) begin n_bad++; $display("FAIL byte_st_lat: got %0d want 3", lat); end
        n_cmp++;
        if (mem[8] !== 16'hA5EF || mem[9] !== 16'hDEAD) begin
            n_bad++; $display("FAIL byte_st_ram: got %h %h want a5ef dead", mem[8], mem[9]);
        end
    endtask

    task automatic test_odd_half();
        int lat, en_cnt;
        logic err, busy_ack;
        logic [31:0] rd;
        run_req(4'b0011, 2'd0, 32'h14, 32'h0000_5678, lat, err, rd, en_cnt, busy_ack);
        n_cmp++;
        if (lat !== 2 || mem[10] !== 16'h5678) begin
            n_bad++; $display("FAIL even_half_st: got lat %0d ram %h want 2 5678", lat, mem[10]);
        end
        run_req(4'b0011, 2'd0, 32'h13, 32'h0000_1234, lat, err, rd, en_cnt, busy_ack);
        n_cmp++;
        if (lat !== 4) begin n_bad++; $display("FAIL odd_half_lat: got %0d want 4", lat); end
        n_cmp++;
        if (mem[9] !== 16'h34AD || mem[10] !== 16'h5612) begin
            n_bad++; $display("FAIL odd_half_ram: got %h %h want 34ad 5612", mem[9], mem[10]);
        end
    endtask

    task automatic test_reads();
        int lat, en_cnt;
        logic err, busy_ack;
        logic [31:0] rd;
        run_req(4'b0000, 2'd1, 32'h13, 32'h0, lat, err, rd, en_cnt, busy_ack);
        n_cmp++;
        if (lat !== 2 || rd !== 32'h0000_1234) begin
            n_bad++; $display("FAIL half_rd_odd: got lat %0d data %h want 2 00001234", lat, rd);
        end
        run_req(4'b0000, 2'd0, 32'h13, 32'h0, lat, err, rd, en_cnt, busy_ack);
        n_cmp++;
        if (lat !== 2 || rd !== 32'h0000_0034) begin
            n_bad++; $display("FAIL byte_rd_odd: got lat %0d data %h want 2 00000034", lat, rd);
        end
    endtask

    task automatic test_errors();
        int lat, en_cnt;
        logic err, busy_ack;
        logic [31:0] rd;
        logic [3:0]  e_we   [3];
        logic [1:0]  e_sz   [3];
        logic [31:0] e_addr [3];
        e_we[0] = 4'b1111; e_sz[0] = 2'd0; e_addr[0] = 32'h3;
        e_we[1] = 4'b0110; e_sz[1] = 2'd0; e_addr[1] = 32'h4;
        e_we[2] = 4'b0000; e_sz[2] = 2'd2; e_addr[2] = 32'(2 * (MEM_WIDTH - 1));
        run_req(4'b1111, 2'd0, 32'h2, 32'h0BAD_CAFE, lat, err, rd, en_cnt, busy_ack);
        n_cmp++;
        if (lat !== 3 || err !== 1'b0 || en_cnt !== 2) begin
            n_bad++; $display("FAIL err_control: got lat %0d err %b en %0d want 3/0/2", lat, err, en_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            run_req(e_we[i], e_sz[i], e_addr[i], 32'hFFFF_FFFF, lat, err, rd, en_cnt, busy_ack);
            n_cmp++;
            if (lat !== 1 || err !== 1'b1) begin
                n_bad++; $display("FAIL err_case%0d_ack: got lat %0d err %b want 1/1", i, lat, err);
            end
            n_cmp++;
            if (en_cnt !== 0 || rd !== 32'h0) begin
                n_bad++; $display("FAIL err_case%0d_quiet: got en %0d rdata %h want 0/0", i, en_cnt, rd);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] ack_map, idle_map;
        int bad_data;
        ack_map = '0; idle_map = '0; bad_data = 0;
        @(negedge clk);
        @(negedge clk);
        req_i = 1'b1; we_i = 4'b0000; size_i = 2'd2; addr_i = 32'h12; wdata_i = 32'h0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            ack_map[c-1]  = ack_o;
            idle_map[c-1] = !busy_o;
            if (ack_o && rdata_o !== 32'h5612_34AD) bad_data++;
        end
        req_i = 1'b0;
        n_cmp++;
        if (ack_map !== 12'h492) begin n_bad++; $display("FAIL b2b_acks: got %h want 492", ack_map); end
        n_cmp++;
        if (idle_map !== 12'h924) begin n_bad++; $display("FAIL b2b_idle: got %h want 924", idle_map); end
        n_cmp++;
        if (bad_data !== 0) begin n_bad++; $display("FAIL b2b_data: got %0d bad acks want 0", bad_data); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_word();
        test_byte_store();
        test_odd_half();
        test_reads();
        test_errors();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
